// File: rtl/disp_pkg.sv
// Shared note-display definitions: segment patterns, note codes and decoder states.
// The display encoder uses the same table, so both ends of the bus stay in step.
package disp_pkg;

  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_G     = 7'h5E;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_REST  = 7'h01;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [2:0] NOTA_C    = 3'd0;
  localparam logic [2:0] NOTA_D    = 3'd1;
  localparam logic [2:0] NOTA_E    = 3'd2;
  localparam logic [2:0] NOTA_F    = 3'd3;
  localparam logic [2:0] NOTA_G    = 3'd4;
  localparam logic [2:0] NOTA_A    = 3'd5;
  localparam logic [2:0] NOTA_B    = 3'd6;
  localparam logic [2:0] NOTA_REST = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } disp_state_e;

endpackage

// File: rtl/disp_seg_lookup.sv
// Combinational map from a 7-segment pattern to its note code.
// Blank and every pattern outside the table are reported as not legal.
module disp_seg_lookup
  import disp_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       legal_o,
  output logic [2:0] nota_o
);

  always_comb begin
    legal_o = 1'b1;
    nota_o  = NOTA_C;
    case (seg_i)
      SEG_C:    nota_o = NOTA_C;
      SEG_D:    nota_o = NOTA_D;
      SEG_E:    nota_o = NOTA_E;
      SEG_F:    nota_o = NOTA_F;
      SEG_G:    nota_o = NOTA_G;
      SEG_A:    nota_o = NOTA_A;
      SEG_B:    nota_o = NOTA_B;
      SEG_REST: nota_o = NOTA_REST;
      default:  legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/disp_decoder.sv
// Receiving end of the note-display bus: debounces the segment pattern, decodes it,
// counts illegal patterns and offers notes downstream through a one-entry buffer.
module disp_decoder
  import disp_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           seg_in,
  input  logic                 tom_in,
  output logic                 note_valid,
  input  logic                 note_ready,
  output logic [2:0]           nota,
  output logic                 tom,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 overrun
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  disp_state_e          state_q;
  logic [7:0]           sample_d, sample_q;
  logic [7:0]           cnt_q;
  logic                 note_valid_q, tom_q, err_pulse_q, overrun_q;
  logic [2:0]           nota_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic       changed, incoming_blank, classify, drain, legal;
  logic [2:0] lookup_nota;

  assign sample_d       = {tom_in, seg_in};
  assign changed        = (sample_d != sample_q);
  assign incoming_blank = (seg_in == SEG_BLANK);
  assign classify       = (state_q == SETTLE) && (cnt_q == CNT_MAX);
  assign drain          = note_valid_q && note_ready;

  disp_seg_lookup u_lookup (
    .seg_i   (sample_q[6:0]),
    .legal_o (legal),
    .nota_o  (lookup_nota)
  );

  // A change seen on the sampling edge restarts the count in the same edge the
  // register takes the new value, so an event lands STABLE_CYCLES edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_q     <= '0;
      cnt_q        <= '0;
      note_valid_q <= 1'b0;
      nota_q       <= '0;
      tom_q        <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      sample_q    <= sample_d;
      err_pulse_q <= 1'b0;
      if (changed) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (drain) begin
        note_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (!incoming_blank) begin
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (classify) begin
            if (legal) begin
              if (!note_valid_q || drain) begin
                note_valid_q <= 1'b1;
                nota_q       <= lookup_nota;
                tom_q        <= sample_q[7];
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              err_pulse_q <= 1'b1;
              if (err_count_q != '1) begin
                err_count_q <= err_count_q + ERR_CNT_W'(1);
              end
            end
            if (!changed) begin
              state_q <= HOLD;
            end else if (incoming_blank) begin
              state_q <= IDLE;
            end
          end else if (changed && incoming_blank) begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (changed) begin
            state_q <= incoming_blank ? IDLE : SETTLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign note_valid = note_valid_q;
  assign nota       = nota_q;
  assign tom        = tom_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_disp_decoder.sv
// Directed bench for disp_decoder: a scoreboard queue of expected notes is filled as
// patterns are driven and drained by a negedge monitor at every handshake.
module tb_disp_decoder;

  localparam int STABLE = 4;

  logic       clk, rst, tom_in, note_ready;
  logic [6:0] seg_in;
  logic       note_valid, tom, err_pulse, overrun;
  logic [2:0] nota;
  logic [7:0] err_count;

  int checks    = 0;
  int failures  = 0;
  int hsCount   = 0;
  int validHigh = 0;
  int errPulses = 0;
  logic [3:0] sbQ[$];

  disp_decoder #(.STABLE_CYCLES(STABLE), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .tom_in     (tom_in),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .nota       (nota),
    .tom        (tom),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .overrun    (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [6:0] seg, input logic t, input int cycles);
    seg_in = seg;
    tom_in = t;
    tick(cycles);
  endtask

  function automatic logic [31:0] allOutputs();
    return 32'({note_valid, nota, tom, err_pulse, err_count, overrun});
  endfunction

  // Inputs change 2 time units after a rising edge, so the falling edge sees
  // settled inputs and outputs; a valid&ready here completes on the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (note_valid) validHigh++;
      if (err_pulse) errPulses++;
      if (note_valid && note_ready) begin
        hsCount++;
        checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 32'd1);
        if (sbQ.size() != 0) begin
          checkOutput("sb_note", 32'({tom, nota}), 32'(sbQ.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [6:0] segTab [8];
    int hsBase, vBase, eBase;
    segTab = '{7'h4E, 7'h3D, 7'h4F, 7'h47, 7'h5E, 7'h77, 7'h1F, 7'h01};

    rst = 1'b1;
    seg_in = 7'h00;
    tom_in = 1'b0;
    note_ready = 1'b0;
    #2;
    checkOutput("reset_outputs", allOutputs(), 32'd0);
    tick(2);
    rst = 1'b0;

    // 1: first event latency, single pulse, no repeat while held
    note_ready = 1'b1;
    hsBase = hsCount;
    vBase = validHigh;
    sbQ.push_back(4'h0);
    applyStimulus(7'h4E, 1'b0, STABLE);
    checkOutput("t1_not_early", 32'(note_valid), 32'd0);
    tick(1);
    checkOutput("t1_valid", 32'(note_valid), 32'd1);
    checkOutput("t1_nota_tom", 32'({nota, tom}), 32'd0);
    tick(1);
    checkOutput("t1_consumed", 32'(note_valid), 32'd0);
    tick(20);
    checkOutput("t1_one_event", 32'(hsCount - hsBase), 32'd1);
    checkOutput("t1_one_valid_cycle", 32'(validHigh - vBase), 32'd1);
    applyStimulus(7'h00, 1'b0, 2);

    // 2: sweep all legal patterns with both tone values
    hsBase = hsCount;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 8; i++) begin
        sbQ.push_back({t[0], i[2:0]});
        applyStimulus(segTab[i], t[0], 6);
        applyStimulus(7'h00, 1'b0, 2);
      end
    end
    checkOutput("t2_events", 32'(hsCount - hsBase), 32'd16);
    checkOutput("t2_err_count", 32'(err_count), 32'd0);
    checkOutput("t2_sb_empty", 32'(sbQ.size()), 32'd0);

    // 3: a pattern too short to settle is ignored
    hsBase = hsCount;
    sbQ.push_back(4'h3);
    applyStimulus(7'h77, 1'b0, 2);
    applyStimulus(7'h47, 1'b0, 6);
    applyStimulus(7'h00, 1'b0, 2);
    checkOutput("t3_events", 32'(hsCount - hsBase), 32'd1);
    checkOutput("t3_sb_empty", 32'(sbQ.size()), 32'd0);

    // 4: illegal pattern counting and saturation
    hsBase = hsCount;
    vBase = validHigh;
    eBase = errPulses;
    for (int k = 0; k < 300; k++) begin
      applyStimulus(7'h7F, 1'b0, 6);
      applyStimulus(7'h00, 1'b0, 1);
    end
    checkOutput("t4_err_pulses", 32'(errPulses - eBase), 32'd300);
    checkOutput("t4_err_count_sat", 32'(err_count), 32'd255);
    checkOutput("t4_no_valid", 32'(validHigh - vBase), 32'd0);
    checkOutput("t4_no_events", 32'(hsCount - hsBase), 32'd0);

    // 5: full buffer drops a note, then drain and load on the same edge
    note_ready = 1'b0;
    sbQ.push_back(4'h0);
    applyStimulus(7'h4E, 1'b0, 6);
    applyStimulus(7'h00, 1'b0, 2);
    checkOutput("t5_hold_valid", 32'({note_valid, nota}), 32'({1'b1, 3'd0}));
    checkOutput("t5_no_overrun_yet", 32'(overrun), 32'd0);
    applyStimulus(7'h4F, 1'b0, 6);
    applyStimulus(7'h00, 1'b0, 2);
    checkOutput("t5_overrun", 32'(overrun), 32'd1);
    checkOutput("t5_kept_first", 32'({note_valid, nota}), 32'({1'b1, 3'd0}));
    sbQ.push_back(4'h4);
    applyStimulus(7'h5E, 1'b0, STABLE);
    note_ready = 1'b1;
    tick(1);
    note_ready = 1'b0;
    checkOutput("t5_reload", 32'({note_valid, nota, tom}), 32'({1'b1, 3'd4, 1'b0}));
    applyStimulus(7'h5E, 1'b0, 1);
    applyStimulus(7'h00, 1'b0, 2);
    note_ready = 1'b1;
    tick(2);
    checkOutput("t5_drained", 32'(note_valid), 32'd0);
    checkOutput("t5_sb_empty", 32'(sbQ.size()), 32'd0);

    // 6a: asynchronous reset in the middle of settling
    applyStimulus(7'h3D, 1'b0, 2);
    #1 rst = 1'b1;
    #1 checkOutput("t6_async_clear", allOutputs(), 32'd0);
    #2 rst = 1'b0;
    sbQ.push_back(4'h1);
    tick(STABLE);
    checkOutput("t6_not_early", 32'(note_valid), 32'd0);
    tick(1);
    checkOutput("t6_fresh_event", 32'({note_valid, nota, tom}), 32'({1'b1, 3'd1, 1'b0}));
    applyStimulus(7'h00, 1'b0, 3);

    // 6b: asynchronous reset with a note pending in the buffer
    note_ready = 1'b0;
    applyStimulus(7'h4F, 1'b1, 6);
    checkOutput("t6_pending", 32'(note_valid), 32'd1);
    #1 rst = 1'b1;
    #1 checkOutput("t6_pending_clear", allOutputs(), 32'd0);
    #2 rst = 1'b0;
    sbQ.push_back(4'hA);
    tick(STABLE);
    checkOutput("t6b_not_early", 32'(note_valid), 32'd0);
    tick(1);
    checkOutput("t6b_fresh_event", 32'({note_valid, nota, tom}), 32'({1'b1, 3'd2, 1'b1}));
    note_ready = 1'b1;
    tick(2);
    checkOutput("t6b_consumed", 32'(note_valid), 32'd0);
    checkOutput("final_sb_empty", 32'(sbQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
